// File: rtl/record_streamer.sv
// Record streamer: buffers 47-bit event records in a FIFO and
// serialises each one as six bytes, LSB first, into a byte sink.
module record_streamer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rec_valid,
    input  logic [46:0]   rec_data,
    input  logic          out_full,
    output logic          out_wr,
    output logic [7:0]    out_data,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic [15:0]   lost_count
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic [47:0]   word, word_nx;
    logic [2:0]    index, index_nx;
    logic [46:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, push, drop;
    logic          not_empty, full;

    assign not_empty = (fifo_count != '0);
    assign full      = (fifo_count == FULL_CNT);
    assign push      = rec_valid && (!full || pop);
    assign drop      = rec_valid && full && !pop;

    // Serializer next state, FIFO pop request and byte outputs.
    always_comb begin
        state_nx = state;
        word_nx  = word;
        index_nx = index;
        pop      = 1'b0;
        out_wr   = 1'b0;
        out_data = 8'h00;
        unique case (state)
            IDLE: begin
                if (not_empty) begin
                    pop      = 1'b1;
                    word_nx  = {1'b0, mem[rd_ptr]};
                    index_nx = 3'd0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                out_wr   = !out_full;
                out_data = word[{index, 3'b000} +: 8];
                if (!out_full) begin
                    if (index == 3'd5) begin
                        index_nx = 3'd0;
                        if (not_empty) begin
                            pop     = 1'b1;
                            word_nx = {1'b0, mem[rd_ptr]};
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        index_nx = index + 3'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            word  <= '0;
            index <= 3'd0;
        end else begin
            state <= state_nx;
            word  <= word_nx;
            index <= index_nx;
        end
    end

    // Record storage; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= rec_data;
        end
    end

    // FIFO pointers, occupancy and drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            lost_count <= 16'h0000;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (lost_count != 16'hFFFF) begin
                    lost_count <= lost_count + 16'h0001;
                end
            end
        end
    end

endmodule

// File: tb/tb_record_streamer.sv
// Bench for record_streamer: queue-level reference model checked
// every cycle, plus directed sequences with literal expectations.
module tb_record_streamer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rec_valid = 1'b0;
    logic [46:0]   rec_data = '0;
    logic          out_full = 1'b0;
    logic          out_wr;
    logic [7:0]    out_data;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic [15:0]   lost_count;

    int tests = 0;
    int fails = 0;

    record_streamer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .rec_valid(rec_valid),
        .rec_data(rec_data),
        .out_full(out_full),
        .out_wr(out_wr),
        .out_data(out_data),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    // Reference model: records waiting, bytes left of the record in flight.
    logic [46:0] m_q[$];
    logic [7:0]  m_cur[$];
    bit          m_busy = 0;
    bit          m_ovf = 0;
    int          m_lost = 0;
    bit          started = 0;

    task automatic chk(input string name, input logic [47:0] got,
                       input logic [47:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit xfer, need, take, accept;
        logic [47:0] w;
        if (reset) begin
            m_q.delete();
            m_cur.delete();
            m_busy = 0;
            m_ovf = 0;
            m_lost = 0;
            started = 1;
        end else begin
            xfer = m_busy && !out_full;
            if (xfer) void'(m_cur.pop_front());
            need = !m_busy || (xfer && m_cur.size() == 0);
            take = need && m_q.size() > 0;
            accept = rec_valid && (m_q.size() < DEPTH || take);
            if (rec_valid && !accept) begin
                m_ovf = 1;
                if (m_lost < 16'hFFFF) m_lost++;
            end
            if (take) begin
                w = {1'b0, m_q.pop_front()};
                for (int k = 0; k < 6; k++) m_cur.push_back(w[8*k +: 8]);
                m_busy = 1;
            end else if (need) begin
                m_busy = 0;
            end
            if (accept) m_q.push_back(rec_data);
        end
    end

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("m_out_wr", out_wr, m_busy && !out_full);
            chk("m_out_data", out_data, m_busy ? m_cur[0] : 8'h00);
            chk("m_fifo_count", fifo_count, m_q.size());
            chk("m_overflow", overflow, m_ovf);
            chk("m_lost_count", lost_count, m_lost);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [46:0] rnd47();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[46:0];
    endfunction

    initial begin
        logic [7:0] exp_b [6];
        exp_b[0] = 8'hAB; exp_b[1] = 8'h89; exp_b[2] = 8'h67;
        exp_b[3] = 8'h45; exp_b[4] = 8'h23; exp_b[5] = 8'h01;

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_count", fifo_count, 0);
        chk("rst_wr", out_wr, 0);
        chk("rst_data", out_data, 0);
        chk("rst_lost", lost_count, 0);

        // Single record latency and byte order.
        rec_valid = 1'b1;
        rec_data = 47'h0123_4567_89AB;
        step();
        rec_valid = 1'b0;
        @(negedge clk);
        chk("lat_count1", fifo_count, 1);
        chk("lat_wr0", out_wr, 0);
        step();
        @(negedge clk);
        chk("lat_count0", fifo_count, 0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                step();
                @(negedge clk);
            end
            chk("seq_wr", out_wr, 1);
            chk("seq_byte", out_data, exp_b[i]);
        end
        step();
        @(negedge clk);
        chk("seq_done_wr", out_wr, 0);

        // Overflow with the sink stalled behind one record in flight.
        out_full = 1'b1;
        rec_valid = 1'b1;
        rec_data = rnd47();
        step();
        repeat (DEPTH + 3) begin
            rec_data = rnd47();
            step();
        end
        rec_valid = 1'b0;
        @(negedge clk);
        chk("ovf_count", fifo_count, DEPTH);
        chk("ovf_flag", overflow, 1);
        chk("ovf_lost", lost_count, 3);
        chk("ovf_stall_wr", out_wr, 0);

        // Let a few bytes go, then reset mid-record.
        out_full = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr", out_wr, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_lost", lost_count, 0);
        repeat (8) step();
        @(negedge clk);
        chk("post_rst_quiet", out_wr, 0);

        // Randomised traffic with phases of varying pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int pv, pf;
            pv = (ph % 3 == 0) ? 90 : ((ph % 3 == 1) ? 20 : 50);
            pf = (ph % 2 == 0) ? 70 : 15;
            repeat (700) begin
                rec_valid = ($urandom_range(99) < pv);
                rec_data = rnd47();
                out_full = ($urandom_range(99) < pf);
                reset = ($urandom_range(499) == 0);
                step();
            end
        end

        // Drain.
        reset = 1'b0;
        rec_valid = 1'b0;
        out_full = 1'b0;
        repeat (6 * DEPTH + 20) step();
        @(negedge clk);
        chk("drain_count", fifo_count, 0);
        chk("drain_wr", out_wr, 0);

        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
